// File: rtl/burst_read_responder_pkg.sv
// Shared burst-read interface definitions: FSM encoding and the request field
// widths that the DMA initiators use as well.
package burst_read_responder_pkg;

    localparam int BURST_ADDR_W = 25;
    localparam int BURST_LEN_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAT,
        ST_STREAM,
        ST_DONE
    } burst_state_t;

    // 32-bit beats carry two halfwords, so an odd length rounds up; the extra
    // bit keeps len=2047 from overflowing before the shift.
    function automatic logic [BURST_LEN_W-1:0] beat_count(
        input logic [BURST_LEN_W-1:0] len,
        input logic                   mode_32
    );
        logic [BURST_LEN_W:0] sum;
        sum = {1'b0, len} + {{BURST_LEN_W{1'b0}}, 1'b1};
        return mode_32 ? sum[BURST_LEN_W:1] : len;
    endfunction

endpackage

// File: rtl/burst_resp_ram.sv
// Simple dual-port scratchpad, one write port and one registered read port.
// Read-first: a same-address write during a read returns the old word.
module burst_resp_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/burst_read_responder.sv
// Responder end of the SDRAM burst-read interface, serving bursts from an
// on-chip scratchpad with a fixed first-beat latency and optional beat gaps.
module burst_read_responder
    import burst_read_responder_pkg::*;
#(
    parameter int ADDR_W        = 12,
    parameter int FIRST_LATENCY = 3,
    parameter int BEAT_GAP      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [31:0]             wr_data,
    input  logic                    burst_rd,
    input  logic [BURST_ADDR_W-1:0] burst_addr,
    input  logic [BURST_LEN_W-1:0]  burst_len,
    input  logic                    burst_32bit,
    output logic [31:0]             burst_data,
    output logic                    burst_data_valid,
    output logic                    burst_data_done,
    output logic                    busy,
    output logic                    overrun
);

    localparam int GAP_W = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;
    localparam int LAT_W = (FIRST_LATENCY > 2) ? $clog2(FIRST_LATENCY) : 1;

    burst_state_t             state;
    burst_state_t             state_next;
    logic                     rd_en;
    logic [LAT_W-1:0]         lat_cnt;
    logic [GAP_W-1:0]         gap_cnt;
    logic [BURST_LEN_W-1:0]   issue_left;
    logic [ADDR_W-1:0]        word_addr;
    logic                     half_sel;
    logic                     mode_32;
    logic                     valid_q;
    logic                     half_q;
    logic                     overrun_q;
    logic [31:0]              ram_q;
    logic [31:0]              beat_data;
    logic [31:0]              hold_data;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^burst_addr[BURST_ADDR_W-1:ADDR_W+1];

    burst_resp_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (word_addr),
        .rd_data (ram_q)
    );

    // Reads are issued one cycle before their beat is due, since the RAM
    // output feeds the data port directly in the following cycle.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (burst_rd) begin
                    state_next = ST_LAT;
                end
            end
            ST_LAT: begin
                if (lat_cnt == '0) begin
                    if (issue_left != '0) begin
                        rd_en      = 1'b1;
                        state_next = ST_STREAM;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_STREAM: begin
                if (issue_left == '0) begin
                    state_next = ST_DONE;
                end else if (gap_cnt == '0) begin
                    rd_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
            issue_left <= '0;
            word_addr  <= '0;
            half_sel   <= 1'b0;
            mode_32    <= 1'b0;
            valid_q    <= 1'b0;
            half_q     <= 1'b0;
            overrun_q  <= 1'b0;
            hold_data  <= '0;
        end else begin
            state   <= state_next;
            valid_q <= rd_en;

            if (burst_rd && state != ST_IDLE) begin
                overrun_q <= 1'b1;
            end

            if (state == ST_IDLE && burst_rd) begin
                lat_cnt    <= LAT_W'(FIRST_LATENCY - 2);
                gap_cnt    <= '0;
                issue_left <= beat_count(burst_len, burst_32bit);
                word_addr  <= burst_addr[ADDR_W:1];
                half_sel   <= burst_addr[0];
                mode_32    <= burst_32bit;
            end else if (state == ST_LAT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            // Halfword mode only moves to the next word after the high half.
            if (rd_en) begin
                issue_left <= issue_left - BURST_LEN_W'(1);
                gap_cnt    <= GAP_W'(BEAT_GAP);
                half_q     <= half_sel;
                if (mode_32 || half_sel) begin
                    word_addr <= word_addr + ADDR_W'(1);
                end
                if (!mode_32) begin
                    half_sel <= ~half_sel;
                end
            end else if (state == ST_STREAM && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            if (valid_q) begin
                hold_data <= beat_data;
            end
        end
    end

    assign beat_data        = mode_32 ? ram_q
                            : {16'h0000, (half_q ? ram_q[31:16] : ram_q[15:0])};
    assign burst_data       = valid_q ? beat_data : hold_data;
    assign burst_data_valid = valid_q;
    assign burst_data_done  = (state == ST_DONE);
    assign busy             = (state == ST_LAT) || (state == ST_STREAM);
    assign overrun          = overrun_q;

endmodule
